bus_regfile_mux: RTL
====================

// Module: bus_regfile_mux
// PURPOSE
//   Parametrised datapath bus with its register file. Successor to the
//   fixed 16-bit/8-register bus multiplexer of the basic CPU.
//   - Drives the shared bus from one one-hot-selected source: din, G, or R0..R(NREG-1).
//   - Owns R0..R(NREG-1), which load from the bus under per-register enables.
//   - Detects illegal selects, holds the bus, and counts completed transfers.
//   - Sits between the control FSM (sel/rin) and the ALU/G register.
// PARAMETERS
//   WORD  16  bus and register width in bits
//   NREG  8   number of general registers, 1..32
//   CNTW  16  width of the transfer counter
// PORTS
//   clk      in   1            rising-edge clock (single clock domain)
//   rst      in   1            synchronous, active-high reset
//   din      in   WORD         external data source
//   g_in     in   WORD         G (ALU result) register value
//   sel      in   NREG+2       one-hot source select: [0]=din, [1]=G, [2+i]=Ri
//   rin      in   NREG         per-register load enables from the bus
//   err_clr  in   1            clears the sticky err flag
//   bus      out  WORD         shared data bus
//   reg_out  out  WORD*NREG    R(NREG-1)..R0 concatenated; Ri at [WORD*i +: WORD]
//   sel_ok   out  1            sel is legal (exactly one bit set), combinational
//   err      out  1            sticky flag: an illegal sel has been seen
//   xfer_cnt out  CNTW         number of completed legal transfers
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//   - Ri=0, hold=0, err=0, xfer_cnt=0.
//   - bus=0 in the following cycle unless a legal sel drives it.
//   - rst has priority over every other input.
//   - A transfer pending when rst is asserted is discarded; no write occurs.
//   Bus (combinational, zero latency):
//   - Legal sel: bus = the selected source.
//   - Illegal sel (zero bits or more than one bit set): bus = hold, the last
//     bus value driven under a legal sel. Sources are never ORed together.
//   - hold updates to bus on every clk edge where sel_ok=1.
//   Register write:
//   - At a clk edge, Ri <= bus for every i with rin[i]=1 and sel_ok=1.
//   - Several rin bits may be set at once (broadcast).
//   - rin[i] with sel selecting Ri leaves Ri unchanged.
//   - Illegal sel blocks all writes.
//   - A written value appears on reg_out, and on bus if Ri is selected,
//     one cycle after the edge.
//   Error flag:
//   - err sets at the edge after any cycle with sel_ok=0.
//   - Only err_clr or rst clears it.
//   - err_clr and a new illegal sel in the same cycle: set wins, err stays 1.
//   Transfer counter:
//   - xfer_cnt += 1 at an edge where sel_ok=1 and |rin=1.
//   - Wraps from 2^CNTW-1 to 0 with no flag.
//   - Broadcast writes count once.
//   Width rules:
//   - No arithmetic on data; all paths are exactly WORD bits.
//   - NREG outside 1..32 is a configuration error; elaboration must fail.
// TESTING
//   1. rst=1 for 2 cycles, sel=0 -> reg_out=0, err=0, xfer_cnt=0.
//      One cycle later, sel=1 and din=16'h0007 -> bus=16'h0007.
//   2. din=16'h00F0, sel[0]=1, rin=8'h01. One cycle later, sel[2]=1 ->
//      bus=16'h00F0, R0=16'h00F0, xfer_cnt=1.
//   3. g_in=16'h8299, sel[1]=1, rin=8'hFF -> all R0..R7=16'h8299,
//      xfer_cnt increments by 1 only.
//   4. Last legal bus=16'hC003, then sel=10'b00_0000_0011 with rin=8'h04 ->
//      bus=16'hC003, sel_ok=0, R2 unchanged, err=1 next cycle.
//      Then err_clr=1 with a legal sel -> err=0.
//   5. err_clr=1 and sel=0 in the same cycle -> err remains 1.
//      rst with rin=8'h02 pending -> R1=0.
//   6. CNTW=4: drive 17 legal transfers -> xfer_cnt=1 (wrapped).
//      Also run WORD=8 and NREG=4: R3 at reg_out[31:24] loads correctly.

Source files
------------

// File: rtl/bus_regfile_mux_if.sv
// Bus/register-file port bundle: control-side sources and selects
// in, bus, register file and status out.
interface bus_regfile_mux_if #(
  parameter int WORD = 16,
  parameter int NREG = 8,
  parameter int CNTW = 16
) ();
  logic [WORD-1:0]      din;
  logic [WORD-1:0]      g_in;
  logic [NREG+1:0]      sel;
  logic [NREG-1:0]      rin;
  logic                 err_clr;
  logic [WORD-1:0]      bus;
  logic [WORD*NREG-1:0] reg_out;
  logic                 sel_ok;
  logic                 err;
  logic [CNTW-1:0]      xfer_cnt;

  modport master (
    output din, g_in, sel, rin, err_clr,
    input  bus, reg_out, sel_ok, err, xfer_cnt
  );

  modport slave (
    input  din, g_in, sel, rin, err_clr,
    output bus, reg_out, sel_ok, err, xfer_cnt
  );
endinterface

// File: rtl/bus_regfile_mux.sv
// Shared datapath bus with one-hot source select, register file,
// hold-on-illegal-select, sticky error flag and transfer counter.
module bus_regfile_mux #(
  parameter int WORD = 16,
  parameter int NREG = 8,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  bus_regfile_mux_if.slave io
);

  if (NREG < 1 || NREG > 32) begin : g_cfg_err
    $error("bus_regfile_mux: NREG must be 1..32");
  end

  logic [WORD-1:0] r_q [NREG];
  logic [WORD-1:0] r_d [NREG];
  logic [WORD-1:0] hold_q, hold_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WORD-1:0] src;
  logic [WORD-1:0] bus;
  logic            sel_ok;

  assign sel_ok = $onehot(io.sel);

  // Only one source can match under a legal select, so no OR-ing.
  always_comb begin
    src = '0;
    if (io.sel[0]) src = io.din;
    if (io.sel[1]) src = io.g_in;
    for (int i = 0; i < NREG; i++) begin
      if (io.sel[2+i]) src = r_q[i];
    end
  end

  assign bus = sel_ok ? src : hold_q;

  always_comb begin
    hold_d = hold_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NREG; i++) begin
      r_d[i] = r_q[i];
    end
    if (sel_ok) begin
      hold_d = bus;
      for (int i = 0; i < NREG; i++) begin
        if (io.rin[i] && !io.sel[2+i]) r_d[i] = bus;
      end
      if (|io.rin) cnt_d = cnt_q + 1'b1;
      if (io.err_clr) err_d = 1'b0;
    end else begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      hold_q <= hold_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NREG; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_rout
    assign io.reg_out[WORD*i +: WORD] = r_q[i];
  end

  assign io.bus      = bus;
  assign io.sel_ok   = sel_ok;
  assign io.err      = err_q;
  assign io.xfer_cnt = cnt_q;

endmodule
